// File: rtl/control_fsm_mc_if.sv
// Instruction, ALU and data-memory signals of the multi-cycle control FSM.
// The master side is the controller; the slave side is its surrounding datapath.
interface control_fsm_mc_if #(
    parameter int ALUOP_W = 4
) ();
    logic               instr_valid;
    logic [31:0]        instr;
    logic               instr_ready;
    logic               alu_zero;
    logic               mem_ack;
    logic               mem_req;
    logic               mem_we;
    logic [ALUOP_W-1:0] ALUop;
    logic               regWEn;
    logic               alu_src_imm;
    logic               pc_en;
    logic               branch_taken;
    logic               illegal;
    logic               timeout;

    modport master (
        input  instr_valid, instr, alu_zero, mem_ack,
        output instr_ready, mem_req, mem_we, ALUop, regWEn, alu_src_imm,
               pc_en, branch_taken, illegal, timeout
    );

    modport slave (
        output instr_valid, instr, alu_zero, mem_ack,
        input  instr_ready, mem_req, mem_we, ALUop, regWEn, alu_src_imm,
               pc_en, branch_taken, illegal, timeout
    );
endinterface

// File: rtl/control_fsm_mc.sv
// Multi-cycle control FSM for an RV32 subset (R/I-ALU, LW, SW, BEQ, BNE).
// Every output is a flop; strobes become visible in the cycle after the edge that decides them.
module control_fsm_mc #(
    parameter int ALUOP_W = 4,
    parameter int MEM_TMO = 15,
    parameter int TMO_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    control_fsm_mc_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [1:0] {KIND_ALU, KIND_LOAD, KIND_STORE, KIND_BRANCH} kind_t;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam logic [ALUOP_W-1:0] ADD_OP = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] SUB_OP = ALUOP_W'(4'b0110);
    localparam logic [ALUOP_W-1:0] XOR_OP = ALUOP_W'(4'b0011);
    localparam logic [ALUOP_W-1:0] OR_OP  = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] AND_OP = ALUOP_W'(4'b0000);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [31:0]        instr_q, instr_d;
    logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               instr_ready_q, instr_ready_d;
    logic               reg_wen_q, reg_wen_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic               alu_src_imm_q, alu_src_imm_d;
    logic               pc_en_q, pc_en_d;
    logic               branch_taken_q, branch_taken_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               f3_ok;
    logic [ALUOP_W-1:0] f3_op;
    logic               dec_legal;
    logic               dec_imm;
    kind_t              dec_kind;
    logic [ALUOP_W-1:0] dec_op;
    logic               unused_operand_bits;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    // Register and immediate fields belong to the datapath, not to control.
    assign unused_operand_bits = ^instr_q[24:15] ^ ^instr_q[11:7];

    always_comb begin
        f3_ok = 1'b1;
        f3_op = ADD_OP;
        case (funct3)
            3'b000:  f3_op = ADD_OP;
            3'b100:  f3_op = XOR_OP;
            3'b110:  f3_op = OR_OP;
            3'b111:  f3_op = AND_OP;
            default: f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec_legal = 1'b0;
        dec_kind  = KIND_ALU;
        dec_op    = ADD_OP;
        dec_imm   = 1'b0;
        case (opcode)
            OPC_R: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = f3_ok;
                    dec_op    = f3_op;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = SUB_OP;
                end
            end
            OPC_I: begin
                dec_legal = f3_ok;
                dec_op    = f3_op;
                dec_imm   = 1'b1;
            end
            OPC_LW: begin
                dec_legal = (funct3 == 3'b010);
                dec_kind  = KIND_LOAD;
                dec_imm   = 1'b1;
            end
            OPC_SW: begin
                dec_legal = (funct3 == 3'b010);
                dec_kind  = KIND_STORE;
                dec_imm   = 1'b1;
            end
            OPC_BR: begin
                dec_legal = (funct3[2:1] == 2'b00);
                dec_kind  = KIND_BRANCH;
                dec_op    = SUB_OP;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        instr_d        = instr_q;
        alu_op_d       = alu_op_q;
        cnt_d          = cnt_q;
        reg_wen_d      = 1'b0;
        mem_req_d      = 1'b0;
        mem_we_d       = 1'b0;
        alu_src_imm_d  = 1'b0;
        pc_en_d        = 1'b0;
        branch_taken_d = 1'b0;
        illegal_d      = illegal_q;
        timeout_d      = timeout_q;
        case (state_q)
            FETCH: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_legal) begin
                    state_d       = EXEC;
                    kind_d        = dec_kind;
                    alu_op_d      = dec_op;
                    alu_src_imm_d = dec_imm;
                end else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                case (kind_q)
                    KIND_ALU: begin
                        state_d   = WB;
                        reg_wen_d = 1'b1;
                        pc_en_d   = 1'b1;
                    end
                    KIND_LOAD, KIND_STORE: begin
                        state_d   = MEM;
                        mem_req_d = 1'b1;
                        mem_we_d  = (kind_q == KIND_STORE);
                        cnt_d     = '0;
                    end
                    default: begin
                        // alu_zero reflects the SUB compare issued during this EXEC cycle.
                        state_d        = FETCH;
                        pc_en_d        = 1'b1;
                        branch_taken_d = bus.alu_zero ^ funct3[0];
                    end
                endcase
            end
            MEM: begin
                if (bus.mem_ack) begin
                    pc_en_d = 1'b1;
                    if (kind_q == KIND_LOAD) begin
                        state_d   = WB;
                        reg_wen_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + TMO_W'(1);
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end
            end
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
        instr_ready_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FETCH;
            kind_q         <= KIND_ALU;
            instr_q        <= '0;
            alu_op_q       <= '0;
            cnt_q          <= '0;
            instr_ready_q  <= 1'b1;
            reg_wen_q      <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            alu_src_imm_q  <= 1'b0;
            pc_en_q        <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            instr_q        <= instr_d;
            alu_op_q       <= alu_op_d;
            cnt_q          <= cnt_d;
            instr_ready_q  <= instr_ready_d;
            reg_wen_q      <= reg_wen_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            alu_src_imm_q  <= alu_src_imm_d;
            pc_en_q        <= pc_en_d;
            branch_taken_q <= branch_taken_d;
            illegal_q      <= illegal_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.instr_ready  = instr_ready_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.ALUop        = alu_op_q;
    assign bus.regWEn       = reg_wen_q;
    assign bus.alu_src_imm  = alu_src_imm_q;
    assign bus.pc_en        = pc_en_q;
    assign bus.branch_taken = branch_taken_q;
    assign bus.illegal      = illegal_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_control_fsm_mc.sv
// Bench for control_fsm_mc: fixed instruction vectors, reset corner cases,
// then random instructions checked against a per-instruction outcome model.
module tb_control_fsm_mc;
    localparam int MEM_TMO = 15;
    localparam int N_VEC   = 18;

    typedef struct {
        logic [31:0] instr;
        logic        alu_zero;
        int          ack_delay;
        logic [3:0]  op;
        logic        src_imm;
        int          cycles;
        int          reg_w;
        int          pc_n;
        logic        taken;
        int          mem_cycles;
        logic        mem_we;
        logic        illegal;
        logic        tmo;
    } vec_t;

    typedef struct {
        int          cycles;
        logic [3:0]  op_exec;
        logic [3:0]  op_end;
        logic        src_imm;
        int          reg_w;
        int          reg_offset;
        int          pc_n;
        logic        taken;
        int          mem_cycles;
        logic        mem_we;
        logic        apart;
        logic        illegal;
        logic        tmo;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;

    vec_t vectors [N_VEC];
    obs_t obs;
    vec_t exp_v;

    control_fsm_mc_if #(.ALUOP_W(4)) bus ();

    control_fsm_mc #(.ALUOP_W(4), .MEM_TMO(MEM_TMO), .TMO_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] ins, input logic z, input int d,
                                 input logic [3:0] op, input logic imm, input int cyc,
                                 input int rw, input int pcn, input logic tk, input int mc,
                                 input logic we, input logic ill, input logic tmo);
        vec_t v;
        v.instr = ins; v.alu_zero = z; v.ack_delay = d; v.op = op; v.src_imm = imm;
        v.cycles = cyc; v.reg_w = rw; v.pc_n = pcn; v.taken = tk; v.mem_cycles = mc;
        v.mem_we = we; v.illegal = ill; v.tmo = tmo;
        return v;
    endfunction

    // Outcome of one instruction, derived from the ISA subset and the cycle-count rules.
    function automatic int funct3Code(input logic [2:0] f3);
        case (f3)
            3'b000:  return 2;
            3'b100:  return 3;
            3'b110:  return 1;
            3'b111:  return 0;
            default: return -1;
        endcase
    endfunction

    function automatic vec_t model(input logic [31:0] ins, input logic z, input int d);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         code;
        int         cls;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        code = -1;
        cls  = 0;
        if (opc == 7'b0110011 && f7 == 7'h00) code = funct3Code(f3);
        if (opc == 7'b0110011 && f7 == 7'h20 && f3 == 3'b000) code = 6;
        if (opc == 7'b0010011) begin code = funct3Code(f3); cls = 1; end
        if (opc == 7'b0000011 && f3 == 3'b010) begin code = 2; cls = 2; end
        if (opc == 7'b0100011 && f3 == 3'b010) begin code = 2; cls = 3; end
        if (opc == 7'b1100011 && f3 <= 3'b001) begin code = 6; cls = 4; end
        if (code < 0)
            return mkv(ins, z, d, 4'd0, 1'b0, 2, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        if (cls <= 1)
            return mkv(ins, z, d, 4'(code), cls == 1, 4, 1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        if (cls == 4)
            return mkv(ins, z, d, 4'(code), 1'b0, 3, 0, 1, z ^ f3[0], 0, 1'b0, 1'b0, 1'b0);
        if (d >= MEM_TMO)
            return mkv(ins, z, d, 4'(code), 1'b1, 3 + MEM_TMO, 0, 0, 1'b0, MEM_TMO, cls == 3, 1'b0, 1'b1);
        if (cls == 2)
            return mkv(ins, z, d, 4'(code), 1'b1, 5 + d, 1, 1, 1'b0, d + 1, 1'b0, 1'b0, 1'b0);
        return mkv(ins, z, d, 4'(code), 1'b1, 4 + d, 0, 1, 1'b0, d + 1, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic doReset(input string tag);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput({tag, ".reset_outputs"},
                    {bus.ALUop, bus.regWEn, bus.mem_req, bus.mem_we, bus.alu_src_imm,
                     bus.pc_en, bus.branch_taken, bus.illegal, bus.timeout}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".ready_after_reset"}, bus.instr_ready, 1);
    endtask

    // Offset 0 is the accepting FETCH cycle; the run ends at the next ready cycle or a halt.
    task automatic applyStimulus(input logic [31:0] ins, input logic z, input int d, output obs_t o);
        int offset;
        int waited;
        o = '{default: 0};
        o.reg_offset = -1;
        o.cycles = -1;
        waited = 0;
        @(negedge clk);
        while (!bus.instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        bus.instr       = ins;
        bus.alu_zero    = z;
        bus.mem_ack     = 1'b0;
        bus.instr_valid = bus.instr_ready;
        offset = 0;
        while (bus.instr_valid && offset < 60) begin
            @(negedge clk);
            offset++;
            bus.instr_valid = 1'b0;
            if (offset == 2) begin
                o.op_exec = bus.ALUop;
                o.src_imm = bus.alu_src_imm;
            end
            if (bus.regWEn) begin
                o.reg_w++;
                o.reg_offset = offset;
            end
            if ((bus.regWEn || bus.branch_taken) && !bus.pc_en) o.apart = 1'b1;
            if (bus.pc_en) o.pc_n++;
            o.taken = o.taken | bus.branch_taken;
            if (bus.mem_req) begin
                o.mem_cycles++;
                o.mem_we = o.mem_we | bus.mem_we;
            end
            bus.mem_ack = bus.mem_req && (o.mem_cycles == d + 1);
            if (bus.instr_ready || bus.illegal || bus.timeout) begin
                o.cycles  = offset;
                o.op_end  = bus.ALUop;
                o.illegal = bus.illegal;
                o.tmo     = bus.timeout;
                bus.instr_valid = 1'b0;
                break;
            end
            bus.instr_valid = 1'b1;
            if (offset >= 60) bus.instr_valid = 1'b0;
        end
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
    endtask

    task automatic checkVector(input vec_t e, input obs_t o, input string tag);
        int bad;
        checkOutput({tag, ".cycles"}, o.cycles, e.cycles);
        checkOutput({tag, ".illegal"}, o.illegal, e.illegal);
        checkOutput({tag, ".timeout"}, o.tmo, e.tmo);
        checkOutput({tag, ".regWEn_pulses"}, o.reg_w, e.reg_w);
        checkOutput({tag, ".pc_en_pulses"}, o.pc_n, e.pc_n);
        checkOutput({tag, ".branch_taken"}, o.taken, e.taken);
        checkOutput({tag, ".mem_req_cycles"}, o.mem_cycles, e.mem_cycles);
        checkOutput({tag, ".mem_we"}, o.mem_we, e.mem_we);
        checkOutput({tag, ".alu_src_imm"}, o.src_imm, e.src_imm);
        checkOutput({tag, ".strobes_apart"}, o.apart, 0);
        if (!e.illegal) begin
            checkOutput({tag, ".ALUop_exec"}, o.op_exec, e.op);
            checkOutput({tag, ".ALUop_hold"}, o.op_end, e.op);
        end
        if (e.reg_w == 1) checkOutput({tag, ".regWEn_offset"}, o.reg_offset, e.cycles - 1);
        if (e.illegal || e.tmo) begin
            bad = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.instr_ready || bus.pc_en || bus.regWEn || bus.mem_req) bad++;
            end
            checkOutput({tag, ".halt_quiet"}, bad, 0);
            checkOutput({tag, ".halt_sticky"}, {bus.illegal, bus.timeout}, {e.illegal, e.tmo});
            doReset(tag);
        end
    endtask

    initial begin
        int bad;
        logic [31:0] ins;
        int sel;
        int d;
        logic z;

        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.alu_zero    = 1'b0;
        bus.mem_ack     = 1'b0;

        //                 instr         z     d   op     imm   cyc rw pc tk    mc  we    ill   tmo
        vectors[0]  = mkv(32'h002081B3, 1'b0, 0,  4'h2, 1'b0, 4,  1, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        vectors[1]  = mkv(32'h40208133, 1'b0, 0,  4'h6, 1'b0, 4,  1, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        vectors[2]  = mkv(32'h0020F133, 1'b1, 0,  4'h0, 1'b0, 4,  1, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        vectors[3]  = mkv(32'h003160B3, 1'b0, 0,  4'h1, 1'b0, 4,  1, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        vectors[4]  = mkv(32'h00500093, 1'b0, 0,  4'h2, 1'b1, 4,  1, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        vectors[5]  = mkv(32'hFFF14093, 1'b0, 0,  4'h3, 1'b1, 4,  1, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        vectors[6]  = mkv(32'h0000A103, 1'b0, 2,  4'h2, 1'b1, 7,  1, 1, 1'b0, 3,  1'b0, 1'b0, 1'b0);
        vectors[7]  = mkv(32'h0020A023, 1'b0, 0,  4'h2, 1'b1, 4,  0, 1, 1'b0, 1,  1'b1, 1'b0, 1'b0);
        vectors[8]  = mkv(32'h0020A023, 1'b1, 3,  4'h2, 1'b1, 7,  0, 1, 1'b0, 4,  1'b1, 1'b0, 1'b0);
        vectors[9]  = mkv(32'h00208063, 1'b1, 0,  4'h6, 1'b0, 3,  0, 1, 1'b1, 0,  1'b0, 1'b0, 1'b0);
        vectors[10] = mkv(32'h00209063, 1'b1, 0,  4'h6, 1'b0, 3,  0, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        vectors[11] = mkv(32'h00209063, 1'b0, 0,  4'h6, 1'b0, 3,  0, 1, 1'b1, 0,  1'b0, 1'b0, 1'b0);
        vectors[12] = mkv(32'h00208063, 1'b0, 0,  4'h6, 1'b0, 3,  0, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0);
        vectors[13] = mkv(32'h0000A103, 1'b0, 14, 4'h2, 1'b1, 19, 1, 1, 1'b0, 15, 1'b0, 1'b0, 1'b0);
        vectors[14] = mkv(32'h0000A103, 1'b0, 15, 4'h2, 1'b1, 18, 0, 0, 1'b0, 15, 1'b0, 1'b0, 1'b1);
        vectors[15] = mkv(32'h00000073, 1'b0, 0,  4'h0, 1'b0, 2,  0, 0, 1'b0, 0,  1'b0, 1'b1, 1'b0);
        vectors[16] = mkv(32'h4020C133, 1'b0, 0,  4'h0, 1'b0, 2,  0, 0, 1'b0, 0,  1'b0, 1'b1, 1'b0);
        vectors[17] = mkv(32'h00008103, 1'b0, 0,  4'h0, 1'b0, 2,  0, 0, 1'b0, 0,  1'b0, 1'b1, 1'b0);

        doReset("init");

        for (int i = 0; i < N_VEC; i++) begin
            applyStimulus(vectors[i].instr, vectors[i].alu_zero, vectors[i].ack_delay, obs);
            checkVector(vectors[i], obs, $sformatf("vec%0d", i));
        end

        // Reset while a load waits for its acknowledge.
        bus.instr       = 32'h0000A103;
        bus.mem_ack     = 1'b0;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midmem.req_before_reset", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midmem.req_dropped", bus.mem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.regWEn || bus.pc_en || bus.mem_req) bad++;
        end
        checkOutput("midmem.no_strobes_after", bad, 0);
        checkOutput("midmem.ready_after", bus.instr_ready, 1);

        for (int i = 0; i < 80; i++) begin
            ins = $urandom;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1: begin
                    ins[6:0] = 7'b0110011;
                    if ($urandom_range(0, 4) != 0)
                        ins[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
                end
                2, 3: ins[6:0] = 7'b0010011;
                4: begin
                    ins[6:0] = 7'b0000011;
                    if ($urandom_range(0, 4) != 0) ins[14:12] = 3'b010;
                end
                5: begin
                    ins[6:0] = 7'b0100011;
                    if ($urandom_range(0, 4) != 0) ins[14:12] = 3'b010;
                end
                6, 7: begin
                    ins[6:0] = 7'b1100011;
                    if ($urandom_range(0, 4) != 0) ins[14:12] = 3'($urandom_range(0, 1));
                end
                8: ins[6:0] = 7'b1110011;
                default: ;
            endcase
            z = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 9) == 0) ? 14 + int'($urandom_range(0, 2))
                                            : int'($urandom_range(0, 3));
            exp_v = model(ins, z, d);
            applyStimulus(ins, z, d, obs);
            checkVector(exp_v, obs, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/control_fsm_mc.md
CONTROL_FSM_MC -- requirements
Module: control_fsm_mc

Parameters
REQ-001 The block SHALL have parameter ALUOP_W, default 4, giving the ALUop width; it SHALL be at least 4.
REQ-002 The block SHALL have parameter MEM_TMO, default 15, giving the maximum cycles spent waiting for mem_ack.
REQ-003 The block SHALL have parameter TMO_W, default 4, giving the timeout counter width; it SHALL be large enough to hold MEM_TMO.

Interface
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 instr_valid  input  1  instruction word present.
REQ-007 instr  input  32  RV32 instruction word.
REQ-008 instr_ready  output  1  instruction accepted this cycle.
REQ-009 alu_zero  input  1  ALU result equals zero.
REQ-010 mem_ack  input  1  data-memory access complete.
REQ-011 mem_req  output  1  data-memory access request.
REQ-012 mem_we  output  1  request is a store.
REQ-013 ALUop  output  ALUOP_W  ALU operation code.
REQ-014 regWEn  output  1  register-file write strobe.
REQ-015 alu_src_imm  output  1  ALU operand B comes from the immediate.
REQ-016 pc_en  output  1  PC update strobe.
REQ-017 branch_taken  output  1  PC loads the branch target.
REQ-018 illegal  output  1  sticky unsupported-instruction flag.
REQ-019 timeout  output  1  sticky memory-timeout flag.

Function
REQ-020 The block SHALL register all outputs; the FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-021 FETCH: instr_ready=1; on instr_valid the block SHALL latch instr and go to DECODE; otherwise it SHALL hold in FETCH.
REQ-022 DECODE: the block SHALL decode the instruction in one cycle and go to EXEC, or to HALT with illegal=1 when the instruction is unsupported.
REQ-023 The block SHALL support the following opcodes:
  - 0110011 (R-type)
  - 0010011 (I-ALU)
  - 0000011 (LW, funct3 010)
  - 0100011 (SW, funct3 010)
  - 1100011 (BEQ funct3 000, BNE funct3 001)
REQ-024 The {funct7,funct3} map SHALL be, zero-extended to ALUOP_W:
  - ADD 0000000_000 -> 0010
  - SUB 0100000_000 -> 0110
  - XOR 0000000_100 -> 0011
  - OR 0000000_110 -> 0001
  - AND 0000000_111 -> 0000
REQ-025 For I-ALU the block SHALL ignore funct7, SHALL use funct3 000/100/110/111 with the same mapping, and SHALL treat funct3 000 as ADD.
REQ-026 Loads, stores and branches SHALL use ADD_op for address generation and SUB_op for compare.
REQ-027 EXEC SHALL drive ALUop, with alu_src_imm=1 for I-ALU, LW and SW and 0 otherwise.
REQ-028 R-type and I-ALU SHALL go from EXEC to WB.
REQ-029 LW and SW SHALL go from EXEC to MEM.
REQ-030 Branches SHALL, in EXEC, set branch_taken = alu_zero XOR funct3[0], pulse pc_en, and return to FETCH.
REQ-031 MEM: mem_req=1 and mem_we=1 for SW.
  - On mem_ack, LW SHALL go to WB and SW SHALL pulse pc_en and go to FETCH.
  - A counter SHALL increment each waiting cycle; on reaching MEM_TMO without ack, the block SHALL set timeout=1, deassert mem_req and go to HALT.
  - An ack arriving in the same cycle the counter reaches MEM_TMO SHALL win.
REQ-032 WB: regWEn=1 and pc_en=1 for exactly one cycle, then FETCH.
REQ-033 regWEn, pc_en and branch_taken SHALL be single-cycle pulses; ALUop SHALL hold its last value outside EXEC.
REQ-034 HALT SHALL be exited only by rst; in HALT all strobes SHALL be 0 and illegal/timeout SHALL hold.
REQ-035 Throughput SHALL be:
  - ALU instructions: 4 cycles.
  - Branches: 3 cycles.
  - Stores: 4+N cycles, where N is the mem_ack wait.
  - Loads: 5+N cycles.

Reset
REQ-036 On rst=1, asynchronously, state SHALL be FETCH; ALUop, regWEn, mem_req, mem_we, alu_src_imm, pc_en, branch_taken, illegal, timeout and the counter SHALL be 0; instr_ready SHALL be 1 on the first cycle after release.
REQ-037 rst asserted mid-MEM SHALL drop mem_req immediately, and no regWEn or pc_en SHALL follow.

Verification
REQ-038 instr 0x002081B3 (add x3,x1,x2) with instr_valid -> ALUop=0010 in EXEC; regWEn and pc_en pulse together 3 cycles after acceptance.
REQ-039 instr 0x40208133 (sub) -> ALUop=0110; instr 0x0020F133 (and) -> ALUop=0000, alu_src_imm=0.
REQ-040 LW 0x0000A103 with mem_ack after 3 cycles -> mem_req high 3 cycles, mem_we=0, then regWEn pulse; SW 0x0020A023 -> mem_we=1, no regWEn.
REQ-041 BEQ with alu_zero=1 -> branch_taken=1 with pc_en; BNE with alu_zero=1 -> branch_taken=0 with pc_en.
REQ-042 Opcode 1110011 -> illegal=1, HALT, instr_ready=0 indefinitely; LW with no mem_ack -> timeout=1 after 15 MEM cycles; rst clears both.
